rot_sched: RTL and testbench

Round-robin scheduler that shares one byte-transpose rotator between two burst requesters (req0 = activation loader, req1 = weight loader). It grants the rotator to one requester for a full 8-word input burst, feeds those words to the rotator, collects the 16 transposed output beats and returns them tagged with the owner ID. It sits between the load units and the rotator, in the same clock and reset domain as both.

---
 rtl/rot_sched.sv | 214 +++++++++++++++++++++
 tb/tb_rot_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_sched.sv
// rot_sched: round-robin scheduler sharing one byte-transpose rotator
// between the activation loader (req0) and the weight loader (req1).
// A grant covers a full BURST_LEN-word input burst. The OUT_BEATS
// rotator beats that follow are returned tagged with the owner ID.
//
// Build option: define ROT_SCHED_TIMEOUT_EN to enable the DRAIN watchdog.
// When enabled, TIMEOUT_CYC silent DRAIN cycles abort the burst and
// pulse err. When it is not defined, DRAIN waits indefinitely and err
// is tied low.

module rot_sched #(
    parameter int WORD_W      = 128,
    parameter int BURST_LEN   = 8,
    parameter int OUT_BEATS   = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_data,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req1_ready,

    output logic              rot_di_valid,
    output logic [WORD_W-1:0] rot_di,
    input  logic              rot_do_valid,
    input  logic [WORD_W-1:0] rot_do,

    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_id,
    output logic              out_last,

    output logic              busy,
    output logic              err
);

    localparam int IN_CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int OUT_CNT_W = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

    localparam logic [IN_CNT_W-1:0]  IN_LAST  = IN_CNT_W'(BURST_LEN - 1);
    localparam logic [OUT_CNT_W-1:0] OUT_LAST = OUT_CNT_W'(OUT_BEATS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           state_q,        state_d;
    logic                 owner_q,        owner_d;
    logic                 rr_ptr_q,       rr_ptr_d;
    logic [IN_CNT_W-1:0]  in_cnt_q,       in_cnt_d;
    logic [OUT_CNT_W-1:0] out_cnt_q,      out_cnt_d;

    logic [WORD_W-1:0]    rot_di_q,       rot_di_d;
    logic                 rot_di_valid_q, rot_di_valid_d;
    logic                 out_valid_q,    out_valid_d;
    logic [WORD_W-1:0]    out_data_q,     out_data_d;
    logic                 out_id_q,       out_id_d;
    logic                 out_last_q,     out_last_d;

    logic                 sel_valid;
    logic [WORD_W-1:0]    sel_data;
    logic                 accept;
    logic                 beat_in;
    logic                 beat;
    logic                 timeout;

    // Only the owner sees ready, and only while its burst is being fed.
    assign req0_ready = (state_q == ST_FEED) && !owner_q;
    assign req1_ready = (state_q == ST_FEED) &&  owner_q;

    assign sel_valid = owner_q ? req1_valid : req0_valid;
    assign sel_data  = owner_q ? req1_data  : req0_data;
    assign accept    = (state_q == ST_FEED) && sel_valid;

    // Rotator beats count only in DRAIN; a watchdog abort swallows a
    // beat that happens to arrive in the same cycle.
    assign beat_in = (state_q == ST_DRAIN) && rot_do_valid;
    assign beat    = beat_in && !timeout;

`ifdef ROT_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

    logic [WD_W-1:0] wd_q, wd_d;

    // Watchdog: count DRAIN cycles since the most recent rotator beat.
    always_comb begin
        wd_d = wd_q;
        if ((state_q != ST_DRAIN) || beat_in) begin
            wd_d = '0;
        end else if (wd_q != WD_LIMIT) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout = (state_q == ST_DRAIN) && (wd_q == WD_LIMIT);
`else
    assign timeout = 1'b0;
`endif

    assign err = timeout;

    // Scheduler FSM: grant, feed BURST_LEN words, then drain OUT_BEATS beats.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) begin
                        owner_d = ~rr_ptr_q;
                    end else begin
                        owner_d = req1_valid;
                    end
                    in_cnt_d = '0;
                    state_d  = ST_FEED;
                end
            end
            ST_FEED: begin
                if (accept) begin
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_d  = '0;
                        rr_ptr_d  = owner_q;
                        out_cnt_d = '0;
                        state_d   = ST_DRAIN;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (timeout) begin
                    out_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else if (beat) begin
                    if (out_cnt_q == OUT_LAST) begin
                        out_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output datapath: forward accepted words and tag returned beats.
    always_comb begin
        rot_di_valid_d = accept;
        rot_di_d       = accept ? sel_data : rot_di_q;
        out_valid_d    = beat;
        out_data_d     = beat ? rot_do  : out_data_q;
        out_id_d       = beat ? owner_q : out_id_q;
        out_last_d     = beat && (out_cnt_q == OUT_LAST);
    end

    // State and output registers; an async reset discards any partial burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            rr_ptr_q       <= 1'b1;
            in_cnt_q       <= '0;
            out_cnt_q      <= '0;
            rot_di_q       <= '0;
            rot_di_valid_q <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_id_q       <= 1'b0;
            out_last_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            rr_ptr_q       <= rr_ptr_d;
            in_cnt_q       <= in_cnt_d;
            out_cnt_q      <= out_cnt_d;
            rot_di_q       <= rot_di_d;
            rot_di_valid_q <= rot_di_valid_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_id_q       <= out_id_d;
            out_last_q     <= out_last_d;
        end
    end

    assign rot_di       = rot_di_q;
    assign rot_di_valid = rot_di_valid_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_id       = out_id_q;
    assign out_last     = out_last_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rot_sched.sv
// tb_rot_sched: randomized, self-checking bench for rot_sched.
// The bench plays both load units and the rotator. A burst-level model
// predicts grants, handshakes and tagged output beats every cycle.
`timescale 1ns/1ps

module tb_rot_sched;

    localparam int W = 128;

`ifdef ROT_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         rot_di_valid;
    logic [W-1:0] rot_di;
    logic         rot_do_valid;
    logic [W-1:0] rot_do;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_id;
    logic         out_last;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    rot_sched #(.WORD_W(W), .BURST_LEN(8), .OUT_BEATS(16), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rot_di_valid(rot_di_valid), .rot_di(rot_di),
        .rot_do_valid(rot_do_valid), .rot_do(rot_do),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_last(out_last),
        .busy(busy), .err(err)
    );

    int vectors = 0;
    int miscompares = 0;

    int p0, p1, pRot;
    bit toggle0;
    int cycleNo;
    int unsigned cnt0, cnt1;

    int mPhase;
    bit mOwner, mLast;
    int mAccepted, mBeats, mWd, mBursts;

    int obsBeats, obsLasts, obsErr;
    bit servedQ[$];

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic budgetFail(input string tag);
        vectors++;
        miscompares++;
        $error("[TB] FAIL %s observed=budget expired expected=completion", tag);
    endtask

    task automatic modelInit();
        mPhase = 0; mOwner = 1'b0; mLast = 1'b1;
        mAccepted = 0; mBeats = 0; mWd = 0;
    endtask

    task automatic applyReset();
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        rot_do_valid = 1'b0; rot_do = '0;
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rot_di_valid", rot_di_valid, 0);
        check("rst_rot_di", rot_di, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_id, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        modelInit();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycleNo = 0;
    endtask

    task automatic applyStimulus();
        bit v0, v1, rdv, acc, beat, expErr, eOl, eOid;
        logic [W-1:0] d0, d1, rd, accData;
        if (toggle0) v0 = (cycleNo % 2 == 0);
        else         v0 = ($urandom_range(0, 99) < p0);
        v1  = ($urandom_range(0, 99) < p1);
        rdv = ($urandom_range(0, 99) < pRot);
        d0  = {8'hA0, 120'(cnt0)};
        d1  = {8'hB1, 120'(cnt1)};
        rd  = {$urandom, $urandom, $urandom, $urandom};
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        rot_do_valid = rdv; rot_do = rd;
        #1;
        expErr = TIMEOUT_ON && (mPhase == 2) && (mWd == 64);
        check("req0_ready", req0_ready, (mPhase == 1) && !mOwner);
        check("req1_ready", req1_ready, (mPhase == 1) &&  mOwner);
        check("busy", busy, mPhase != 0);
        check("err", err, expErr);
        if (err) obsErr++;

        acc     = (mPhase == 1) && (mOwner ? v1 : v0);
        accData = mOwner ? d1 : d0;
        beat    = (mPhase == 2) && rdv && !expErr;
        eOl     = beat && (mBeats == 15);
        eOid    = mOwner;

        if (mPhase == 0) begin
            if (v0 || v1) begin
                mOwner = (v0 && v1) ? !mLast : v1;
                mPhase = 1;
                mAccepted = 0;
            end
        end else if (mPhase == 1) begin
            if (acc) begin
                if (mOwner) cnt1++; else cnt0++;
                mAccepted++;
                if (mAccepted == 8) begin
                    mLast = mOwner; mPhase = 2; mBeats = 0; mWd = 0;
                end
            end
        end else begin
            if (expErr) begin
                mPhase = 0; mBursts++;
            end else if (beat) begin
                mBeats++; mWd = 0;
                if (mBeats == 16) begin
                    mPhase = 0; mBursts++;
                end
            end else begin
                mWd++;
            end
        end

        @(posedge clk);
        @(negedge clk);
        cycleNo++;
        checkOutput(acc, accData, beat, rd, eOid, eOl);
    endtask

    task automatic checkOutput(input bit acc, input logic [W-1:0] accData, input bit beat,
                               input logic [W-1:0] rd, input bit eOid, input bit eOl);
        check("rot_di_valid", rot_di_valid, acc);
        if (acc) check("rot_di", rot_di, accData);
        check("out_valid", out_valid, beat);
        check("out_last", out_last, eOl);
        if (beat) begin
            check("out_data", out_data, rd);
            check("out_id", out_id, eOid);
        end
        if (out_valid) obsBeats++;
        if (out_valid && out_last) begin
            obsLasts++;
            servedQ.push_back(out_id);
        end
    endtask

    task automatic runBursts(input int n, input int budget);
        int target = mBursts + n;
        while (mBursts < target && budget > 0) begin
            applyStimulus();
            budget--;
        end
        if (mBursts < target) budgetFail("burst_budget");
    endtask

    task automatic runUntilAccepted(input int k, input int budget);
        while (!(mPhase == 1 && mAccepted == k) && budget > 0) begin
            applyStimulus();
            budget--;
        end
        if (!(mPhase == 1 && mAccepted == k)) budgetFail("accept_budget");
    endtask

    task automatic runUntilBeats(input int k, input int budget);
        while (!(mPhase == 2 && mBeats == k) && budget > 0) begin
            applyStimulus();
            budget--;
        end
        if (!(mPhase == 2 && mBeats == k)) budgetFail("beat_budget");
    endtask

    task automatic clearObs();
        obsBeats = 0; obsLasts = 0; obsErr = 0;
        servedQ.delete();
    endtask

    initial begin
        cnt0 = 0; cnt1 = 0; mBursts = 0; toggle0 = 1'b0; cycleNo = 0;
        clearObs();
        applyReset();

        $display("[TB] req0-only burst");
        p0 = 100; p1 = 0; pRot = 100;
        runBursts(1, 200);
        check("a_beats", obsBeats, 16);
        check("a_lasts", obsLasts, 1);
        check("a_owner", (servedQ.size() > 0) ? servedQ[0] : 1'bx, 0);

        $display("[TB] both requesting from reset");
        clearObs();
        applyReset();
        p0 = 100; p1 = 100; pRot = 60;
        runBursts(3, 600);
        check("b_count", servedQ.size(), 3);
        if (servedQ.size() == 3) begin
            check("b_owner0", servedQ[0], 0);
            check("b_owner1", servedQ[1], 1);
            check("b_owner2", servedQ[2], 0);
        end

        $display("[TB] req0 toggling valid during feed");
        clearObs();
        applyReset();
        toggle0 = 1'b1; p1 = 100; pRot = 70;
        runBursts(1, 300);
        toggle0 = 1'b0;
        check("c_owner", (servedQ.size() > 0) ? servedQ[0] : 1'bx, 0);
        check("c_beats", obsBeats, 16);

        $display("[TB] random traffic");
        clearObs();
        p0 = 50; p1 = 50; pRot = 50;
        runBursts(12, 3000);
        check("d_lasts", obsLasts, 12);

        $display("[TB] reset after four accepted words");
        p0 = 100; p1 = 30; pRot = 50;
        runUntilAccepted(4, 300);
        clearObs();
        applyReset();
        p0 = 100; p1 = 100; pRot = 80;
        runBursts(1, 300);
        check("e_owner", (servedQ.size() > 0) ? servedQ[0] : 1'bx, 0);

        if (TIMEOUT_ON) begin
            $display("[TB] rotator stall after five beats");
            clearObs();
            applyReset();
            p0 = 100; p1 = 0; pRot = 100;
            runUntilBeats(5, 200);
            pRot = 0; p0 = 0;
            runBursts(1, 200);
            check("f_err_pulses", obsErr, 1);
            check("f_lasts", obsLasts, 0);
            applyStimulus();
            check("f_idle_busy", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
